// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory stage: data word and access-FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {StIdle, StAccess, StHold} mau_state_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/link_reg.sv
// Load-linked reservation: set by LL completion, cleared by SC completion or a
// matching invalidation (which also wins over a coincident LL to that address).
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ll_done,
  input  word_t ll_addr,
  input  logic  sc_done,
  input  logic  inv_valid,
  input  word_t inv_addr,
  output logic  link_valid,
  output word_t link_addr
);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (ll_done) begin
      valid_d = 1'b1;
      addr_d  = ll_addr;
    end
    if (sc_done) valid_d = 1'b0;
    // Compare against the post-LL address so a same-cycle invalidate kills the new link.
    if (inv_valid && (inv_addr[31:2] == addr_d[31:2])) valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign link_valid = valid_q;
  assign link_addr  = addr_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-cache access unit with load buffer and writeback mux.
// Optional LL/SC support is compiled in with macro LL_SC_EN.
module mem_access_unit
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dren_in,
  input  logic        dwen_in,
  input  logic        jal_s_in,
  input  logic        lui_in,
  input  logic        halt_in,
  input  word_t       alu_portOut_in,
  input  word_t       rdat2_in,
  input  word_t       pcplusfour_in,
  input  logic [15:0] imm_addr_in,
  input  logic        pipe_en,
  input  logic        dhit,
  input  word_t       dmemload,
`ifdef LL_SC_EN
  input  logic        ll_in,
  input  logic        sc_in,
  input  logic        inv_valid,
  input  word_t       inv_addr,
`endif
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       dmemaddr,
  output word_t       dmemstore,
  output word_t       wdat_out,
  output logic        stall_for_data,
  output logic        misalign_err
);

  mau_state_t state_q, state_d;
  word_t      load_buf_q;
  word_t      addr_al, wdat;
  logic       op, is_read, req_raw, req, done, sc_block;

  assign op      = dren_in | dwen_in;
  assign is_read = dren_in;  // read wins when both enables are set
  assign addr_al = word_align(alu_portOut_in);

`ifdef LL_SC_EN
  logic  link_valid, sc_ok, sc_store;
  word_t link_addr;

  assign sc_store = sc_in & ~is_read;
  assign sc_ok    = link_valid & (link_addr == addr_al);
  assign sc_block = sc_store & ~sc_ok;

  link_reg u_link_reg (
    .CLK        (CLK),
    .nRST       (nRST),
    .ll_done    (done & is_read & ll_in),
    .ll_addr    (addr_al),
    .sc_done    (sc_store & (done | (sc_block & req_raw))),
    .inv_valid  (inv_valid),
    .inv_addr   (inv_addr),
    .link_valid (link_valid),
    .link_addr  (link_addr)
  );
`else
  assign sc_block = 1'b0;
`endif

  always_comb begin
    req_raw = 1'b0;
    unique case (state_q)
      StIdle:   req_raw = op & ~halt_in;
      StAccess: req_raw = op;
      StHold:   req_raw = 1'b0;
      default:  req_raw = 1'b0;
    endcase
  end

  assign req  = req_raw & ~sc_block;
  assign done = req & dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAccess: begin
        if (req) state_d = dhit ? (pipe_en ? StIdle : StHold) : StAccess;
        else     state_d = StIdle;
      end
      StHold:  if (pipe_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_buf_q <= '0;
    end else if (done && is_read) begin
      load_buf_q <= dmemload;
`ifdef LL_SC_EN
    end else if (done && sc_store) begin
      load_buf_q <= 32'd1;
`endif
    end
  end

  always_comb begin
    wdat = alu_portOut_in;
    if (jal_s_in)                              wdat = pcplusfour_in;
    else if (lui_in)                           wdat = {imm_addr_in, 16'h0000};
`ifdef LL_SC_EN
    else if (sc_store)                         wdat = (state_q == StHold) ? load_buf_q
                                                                          : {31'b0, sc_ok & req};
`endif
    else if ((state_q == StHold) && is_read)   wdat = load_buf_q;
    else if (done && is_read)                  wdat = dmemload;
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign dmemREN        = nRST & req & is_read;
  assign dmemWEN        = nRST & req & dwen_in & ~is_read;
  assign stall_for_data = nRST & req & ~dhit;
  assign misalign_err   = nRST & req & (alu_portOut_in[1:0] != 2'b00);
  assign dmemaddr       = nRST ? addr_al : '0;
  assign dmemstore      = nRST ? rdat2_in : '0;
  assign wdat_out       = nRST ? wdat : '0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: CLK in 1 clock; nRST in 1 async active-low reset.
REQ-002 SHALL have inputs from EX/MEM: dren_in 1, dwen_in 1, jal_s_in 1, lui_in 1, halt_in 1, alu_portOut_in word_t (address or ALU result), rdat2_in word_t (store data), pcplusfour_in word_t, imm_addr_in 16.
REQ-003 SHALL have pipe_en in 1, high when the MEM/WB latch captures this cycle.
REQ-004 SHALL have cache-side ports: dhit in 1, dmemload in word_t, dmemREN out 1, dmemWEN out 1, dmemaddr out word_t, dmemstore out word_t.
REQ-005 SHALL have outputs to MEM/WB: wdat_out word_t, stall_for_data out 1, misalign_err out 1.
REQ-006 SHALL have ll_in 1, sc_in 1, inv_valid 1, inv_addr word_t, present only under LL_SC_EN.

Function
REQ-007 SHALL run FSM IDLE, ACCESS, HOLD.
REQ-008 IDLE: dren_in|dwen_in with halt_in low -> request driven same cycle (combinational); dhit&pipe_en stays IDLE; dhit&!pipe_en -> HOLD; !dhit -> ACCESS.
REQ-009 ACCESS: request held stable; dhit&pipe_en -> IDLE; dhit&!pipe_en -> HOLD; else remain.
REQ-010 HOLD: no request asserted; pipe_en -> IDLE.
REQ-011 dmemREN=dren_in, dmemWEN=dwen_in while requesting (IDLE-with-op or ACCESS); never both high; dren_in&dwen_in together SHALL be treated as a read.
REQ-012 dmemaddr = {alu_portOut_in[31:2],2'b00}; dmemstore = rdat2_in.
REQ-013 misalign_err SHALL be high for a cycle with a request and alu_portOut_in[1:0]!=0; the access still proceeds.
REQ-014 stall_for_data = request asserted & !dhit; low in HOLD and IDLE-without-op.
REQ-015 On a read with dhit, dmemload SHALL be latched into a load buffer.
REQ-016 wdat_out priority: jal_s_in -> pcplusfour_in; lui_in -> {imm_addr_in,16'h0}; read in HOLD -> buffer; read with dhit -> dmemload; else alu_portOut_in.
REQ-017 halt_in high SHALL suppress new requests from IDLE; an ACCESS in flight SHALL complete.
REQ-018 Zero-wait hit (dhit in first cycle) SHALL add no stall cycles.

Reset
REQ-019 nRST low SHALL asynchronously force state IDLE, load buffer 0, link_valid 0, link_addr 0.
REQ-020 During reset all outputs SHALL be 0; reset mid-ACCESS SHALL drop the request immediately.

Configuration
REQ-021 Macro LL_SC_EN SHALL compile in load-linked/store-conditional support.
REQ-022 With LL_SC_EN: ll_in is a read that, on completion, sets link_valid=1, link_addr=dmemaddr.
REQ-023 With LL_SC_EN: sc_in with link_valid & link_addr==dmemaddr performs the store and wdat_out=1; otherwise no dmemWEN, no stall, wdat_out=0; any sc_in completion clears link_valid.
REQ-024 With LL_SC_EN: inv_valid & inv_addr[31:2]==link_addr[31:2] clears link_valid; if coincident with LL completion to the same address, link_valid SHALL end 0.
REQ-025 Without LL_SC_EN: the ports in REQ-006 and link registers are absent; behaviour is REQ-007..020 only.

Structure
REQ-026 word_t and an mau_state_t enum SHALL live in cpu_types_pkg.
REQ-027 Link register logic SHALL be a sub-module link_reg, instantiated only under LL_SC_EN.

Verification
REQ-028 Read, alu_portOut_in=0x100, dhit after 3 cycles, pipe_en=1 -> stall_for_data high 3 cycles, wdat_out=dmemload (0xDEADBEEF) on the hit cycle, then IDLE.
REQ-029 Read hit with pipe_en=0 for 2 cycles -> HOLD, dmemREN=0, wdat_out holds 0xDEADBEEF, returns to IDLE on pipe_en.
REQ-030 Store to 0x203 -> dmemaddr=0x200, misalign_err=1, dmemWEN until dhit.
REQ-031 jal_s_in=1, pcplusfour_in=0x44 -> wdat_out=0x44, no request; lui_in, imm=0x1234 -> 0x12340000.
REQ-032 LL_SC_EN: ll 0x300, sc 0x300 -> store, wdat_out=1; ll 0x300, inv_addr=0x300, sc -> no dmemWEN, wdat_out=0.
REQ-033 nRST asserted mid-ACCESS -> dmemREN/dmemWEN/stall_for_data 0 immediately, state IDLE.
